bus_protocol_master: RTL and testbench

- Transmit-side master for the dValid/dAck byte bus.
- Accepts bytes from an upstream ready/valid source into a small FIFO, then drives one byte per transfer onto data/dValid.
- Ends each transfer on the target's dAck, keeping dValid high for 2 to 4 clocks.
- Sits directly upstream of the bus target; its outputs are the signals the bus protocol checker monitors.

---
 rtl/bus_protocol_master_if.sv | 19 +
 rtl/bus_protocol_master.sv | 142 ++++++++++++++
 tb/tb_bus_protocol_master.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_protocol_master_if.sv
// Upstream ready/valid byte input and dValid/dAck bus output of the transmit master.
interface bus_protocol_master_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       dValid;
    logic [7:0] data;
    logic       dAck;

    modport master (
        input  in_data, in_valid, dAck,
        output in_ready, dValid, data
    );

    modport slave (
        output in_data, in_valid, dAck,
        input  in_ready, dValid, data
    );
endinterface

// File: rtl/bus_protocol_master.sv
// Transmit master: buffers upstream bytes in a FIFO and sends each one as a
// 2..4 beat dValid pulse, ending on dAck or timing out with bounded relaunches.
//
// state | meaning
// IDLE  | nothing in flight, waiting for the FIFO to hold a byte
// VALID | dValid high, counting beats and watching dAck
// GAP   | single dValid-low cycle between transfers
module bus_protocol_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RETRY  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    bus_protocol_master_if.master  bus,
    output logic                   busy,
    output logic                   tx_done,
    output logic                   tx_drop,
    output logic [7:0]             err_cnt
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] VALID = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;

    logic [1:0]    state;
    logic [2:0]    beat;
    logic [7:0]    retry_cnt;
    logic          relaunch;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign push  = bus.in_valid && !full;
    // Relaunches reuse the data register, so only fresh launches consume an entry.
    assign pop   = !empty && ((state == IDLE) || (state == GAP && !relaunch));

    assign bus.in_ready = !full;
    assign busy         = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= 3'd0;
            bus.dValid <= 1'b0;
            bus.data   <= 8'h00;
            tx_done    <= 1'b0;
            tx_drop    <= 1'b0;
            err_cnt    <= 8'h00;
            retry_cnt  <= 8'h00;
            relaunch   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        bus.data   <= mem[rd_ptr];
                        bus.dValid <= 1'b1;
                        beat       <= 3'd1;
                        state      <= VALID;
                    end
                end
                VALID: begin
                    // An ack on the first beat is ignored to guarantee two beats.
                    if (bus.dAck && beat != 3'd1) begin
                        bus.dValid <= 1'b0;
                        tx_done    <= 1'b1;
                        retry_cnt  <= 8'h00;
                        state      <= GAP;
                    end else if (beat == 3'd4) begin
                        bus.dValid <= 1'b0;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        if (retry_cnt < RETRY_LIM) begin
                            retry_cnt <= retry_cnt + 8'd1;
                            relaunch  <= 1'b1;
                        end else begin
                            tx_drop   <= 1'b1;
                            retry_cnt <= 8'h00;
                        end
                        state <= GAP;
                    end else begin
                        beat <= beat + 3'd1;
                    end
                end
                GAP: begin
                    if (relaunch) begin
                        relaunch   <= 1'b0;
                        bus.dValid <= 1'b1;
                        beat       <= 3'd1;
                        state      <= VALID;
                    end else if (!empty) begin
                        bus.data   <= mem[rd_ptr];
                        bus.dValid <= 1'b1;
                        beat       <= 3'd1;
                        state      <= VALID;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.dValid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_protocol_master.sv
// Directed bench for bus_protocol_master: scoreboard of launched bytes plus
// pulse-length, gap and status checks around each scenario.
module tb_bus_protocol_master;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy, tx_done, tx_drop;
    logic [7:0] err_cnt;

    bus_protocol_master_if bif ();

    bus_protocol_master #(.FIFO_DEPTH(4), .MAX_RETRY(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bif.master),
        .busy    (busy),
        .tx_done (tx_done),
        .tx_drop (tx_drop),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];
    int         len_q[$];
    int         gap_q[$];

    logic       prev_dv = 1'b0;
    logic [7:0] cur_data = 8'h00;
    int         hi_cnt = 0;
    int         lo_cnt = 0;
    bit         saw_fall = 1'b0;
    int         done_cnt = 0;
    int         drop_cnt = 0;
    bit         ready_low_seen = 1'b0;
    int         cyc = 0;
    int         first_rise_cyc = -1;
    int         last_done_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        len_q.delete();
        gap_q.delete();
        saw_fall       = 1'b0;
        done_cnt       = 0;
        drop_cnt       = 0;
        ready_low_seen = 1'b0;
        first_rise_cyc = -1;
        last_done_cyc  = -1;
    endtask

    // One clock: advance past the edge, then run the scoreboard monitor.
    task automatic tick();
        logic was_reset;
        was_reset = reset;
        @(posedge clk);
        #1;
        cyc++;
        if (was_reset) begin
            exp_q.delete();
            prev_dv  = bif.dValid;
            hi_cnt   = 0;
            lo_cnt   = 0;
            saw_fall = 1'b0;
        end else begin
            if (tx_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                chk("done_has_byte", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (tx_drop) begin
                drop_cnt++;
                chk("drop_has_byte", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (bif.dValid) begin
                if (!prev_dv) begin
                    if (first_rise_cyc < 0) first_rise_cyc = cyc;
                    if (saw_fall) gap_q.push_back(lo_cnt);
                    if (exp_q.size() > 0) begin
                        chk("launch_data", 32'(bif.data), 32'(exp_q[0]));
                    end else begin
                        chk("launch_expected", 32'd0, 32'd1);
                    end
                    cur_data = bif.data;
                    hi_cnt   = 1;
                end else begin
                    hi_cnt++;
                    chk("data_hold", 32'(bif.data), 32'(cur_data));
                    if (hi_cnt > 4) chk("pulse_max4", 32'(hi_cnt), 32'd4);
                end
            end else begin
                if (prev_dv) begin
                    len_q.push_back(hi_cnt);
                    chk("data_hold_fall", 32'(bif.data), 32'(cur_data));
                    lo_cnt   = 1;
                    saw_fall = 1'b1;
                    hi_cnt   = 0;
                end else begin
                    lo_cnt++;
                end
            end
            prev_dv = bif.dValid;
        end
        if (!bif.in_ready) ready_low_seen = 1'b1;
    endtask

    // ack_beat: 0 = never ack, 1 = dAck tied high, n = ack when beat n is sampled.
    task automatic run(input int ack_beat, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if (src_q.size() > 0 && bif.in_ready) begin
                bif.in_data  = src_q.pop_front();
                bif.in_valid = 1'b1;
                exp_q.push_back(bif.in_data);
            end else begin
                bif.in_valid = 1'b0;
            end
            if (ack_beat == 0)      bif.dAck = 1'b0;
            else if (ack_beat == 1) bif.dAck = 1'b1;
            else                    bif.dAck = bif.dValid && (hi_cnt == ack_beat);
            tick();
        end
        bif.in_valid = 1'b0;
        bif.dAck     = 1'b0;
    endtask

    initial begin
        bif.in_data  = 8'h00;
        bif.in_valid = 1'b0;
        bif.dAck     = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_dvalid", 32'(bif.dValid), 32'd0);
        chk("rst_data", 32'(bif.data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_done_drop", 32'({tx_done, tx_drop}), 32'd0);
        reset = 1'b0;
        tick();

        // Single byte, ack at beat 2
        clear_stats();
        bif.in_data  = 8'hA5;
        bif.in_valid = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        bif.in_valid = 1'b0;
        chk("t1_e0_dvalid", 32'(bif.dValid), 32'd0);
        tick();
        chk("t1_e1_dvalid", 32'(bif.dValid), 32'd1);
        chk("t1_e1_data", 32'(bif.data), 32'hA5);
        tick();
        chk("t1_e2_dvalid", 32'(bif.dValid), 32'd1);
        bif.dAck = 1'b1;
        tick();
        bif.dAck = 1'b0;
        chk("t1_fall_dvalid", 32'(bif.dValid), 32'd0);
        chk("t1_tx_done", 32'(tx_done), 32'd1);
        chk("t1_data_after", 32'(bif.data), 32'hA5);
        tick();
        chk("t1_done_pulse", 32'(tx_done), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_len", 32'(len_q.size() == 1 ? len_q[0] : -1), 32'd2);

        // Three bytes, ack at beat 3
        clear_stats();
        src_q = '{8'h11, 8'h22, 8'h33};
        run(3, 16);
        chk("t2_done_cnt", 32'(done_cnt), 32'd3);
        chk("t2_pulses", 32'(len_q.size()), 32'd3);
        foreach (len_q[i]) chk("t2_len", 32'(len_q[i]), 32'd3);
        foreach (gap_q[i]) chk("t2_gap", 32'(gap_q[i]), 32'd1);
        chk("t2_gaps", 32'(gap_q.size()), 32'd2);
        chk("t2_in_ready_high", 32'(ready_low_seen), 32'd0);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // dAck tied high: 2-beat transfers, 4 bytes in 12 cycles
        clear_stats();
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run(1, 18);
        chk("t3_done_cnt", 32'(done_cnt), 32'd4);
        foreach (len_q[i]) chk("t3_len", 32'(len_q[i]), 32'd2);
        chk("t3_span", 32'(last_done_cyc - first_rise_cyc + 1), 32'd12);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Timeout, one relaunch, then drop
        clear_stats();
        src_q = '{8'h5C};
        run(0, 14);
        chk("t4_pulses", 32'(len_q.size()), 32'd2);
        foreach (len_q[i]) chk("t4_len", 32'(len_q[i]), 32'd4);
        chk("t4_gap", 32'(gap_q.size() == 1 ? gap_q[0] : -1), 32'd1);
        chk("t4_err_cnt", 32'(err_cnt), 32'd2);
        chk("t4_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("t4_done_cnt", 32'(done_cnt), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);

        // Fill the FIFO while the target stalls
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            bif.in_data  = 8'hB0 + 8'(i);
            bif.in_valid = 1'b1;
            exp_q.push_back(bif.in_data);
            tick();
        end
        chk("t5_full_in_ready", 32'(bif.in_ready), 32'd0);
        chk("t5_beat4", 32'(hi_cnt), 32'd4);
        bif.in_data  = 8'hEE;
        bif.in_valid = 1'b1;
        bif.dAck     = 1'b1;
        tick();
        chk("t5_still_full", 32'(bif.in_ready), 32'd0);
        chk("t5_tx_done", 32'(tx_done), 32'd1);
        bif.in_valid = 1'b0;
        bif.dAck     = 1'b0;
        tick();
        chk("t5_ready_after_pop", 32'(bif.in_ready), 32'd1);
        run(2, 20);
        chk("t5_done_cnt", 32'(done_cnt), 32'd5);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t5_err_cnt", 32'(err_cnt), 32'd2);

        // Reset mid-transfer with 3 bytes queued
        clear_stats();
        src_q = '{8'h61, 8'h62, 8'h63, 8'h64};
        run(0, 8);
        chk("t6_beat2", 32'(hi_cnt), 32'd2);
        chk("t6_dvalid_pre", 32'(bif.dValid), 32'd1);
        chk("t6_err_pre", 32'(err_cnt), 32'd3);
        reset = 1'b1;
        tick();
        chk("t6_dvalid", 32'(bif.dValid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_err_cnt", 32'(err_cnt), 32'd0);
        chk("t6_in_ready", 32'(bif.in_ready), 32'd1);
        chk("t6_no_pulse", 32'({tx_done, tx_drop}), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t6_quiet_dvalid", 32'(bif.dValid), 32'd0);
        chk("t6_quiet_busy", 32'(busy), 32'd0);
        chk("t6_quiet_pulses", 32'(done_cnt + drop_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
